mem_port_arbiter: RTL and testbench

//  Shares the single-port synchronous program/data memory between two requesters: the CPU
//  (LDM/STM/fetch cycles from the controller) and a DMA/loader port (program load, I/O buffer).

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between a CPU port and a
// DMA port. Optional CPU stall counter is built when MEM_ARB_WAIT_CNT_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,

    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_ack_o,
    output logic [DATA_W-1:0] dma_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy_o,
    output logic [7:0]        cpu_wait_cnt_o
);

    // state | meaning
    // IDLE  | sample requests, choose owner, latch its command
    // GRANT | latched command on the memory port, access at closing edge
    // DONE  | one-cycle ack to the owner with read data
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic              lat_we_q, lat_we_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
    logic [DATA_W-1:0] dma_hold_q, dma_hold_d;
    logic              grant_dma;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            cpu_hold_q  <= '0;
            dma_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            dma_hold_q  <= dma_hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        dma_hold_d  = dma_hold_q;
        grant_dma   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_i || dma_req_i) begin
                    // On a tie the side that was not served last wins.
                    grant_dma   = dma_req_i && (!cpu_req_i || !last_q);
                    sel_d       = grant_dma;
                    lat_we_d    = grant_dma ? dma_we_i    : cpu_we_i;
                    lat_addr_d  = grant_dma ? dma_addr_i  : cpu_addr_i;
                    lat_wdata_d = grant_dma ? dma_wdata_i : cpu_wdata_i;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                last_d  = sel_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!lat_we_q) begin
                    if (sel_q) dma_hold_d = mem_rdata_i;
                    else       cpu_hold_d = mem_rdata_i;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_ack_o   = 1'b0;
        dma_ack_o   = 1'b0;
        cpu_rdata_o = '0;
        dma_rdata_o = '0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        busy_o      = (state_q != ST_IDLE);

        if (state_q == ST_GRANT) begin
            mem_en_o    = 1'b1;
            mem_we_o    = lat_we_q;
            mem_addr_o  = lat_addr_q;
            mem_wdata_o = lat_wdata_q;
        end

        // The memory output register holds the read word through DONE; writes show the last read.
        if (state_q == ST_DONE) begin
            if (sel_q) begin
                dma_ack_o   = 1'b1;
                dma_rdata_o = lat_we_q ? dma_hold_q : mem_rdata_i;
            end else begin
                cpu_ack_o   = 1'b1;
                cpu_rdata_o = lat_we_q ? cpu_hold_q : mem_rdata_i;
            end
        end
    end

`ifdef MEM_ARB_WAIT_CNT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       cpu_served;

    assign cpu_served = ((state_q == ST_GRANT) || (state_q == ST_DONE)) && !sel_q;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (cpu_req_i && !cpu_served && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) wait_cnt_q <= 8'd0;
        else         wait_cnt_q <= wait_cnt_d;
    end

    assign cpu_wait_cnt_o = wait_cnt_q;
`else
    assign cpu_wait_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers queue transactions, a negedge monitor
// scores every ack against a transaction-level memory model.
module tb_mem_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_ack;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [7:0]    wait_cnt;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .reset_i(reset),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
        .dma_ack_o(dma_ack), .dma_rdata_o(dma_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .busy_o(busy), .cpu_wait_cnt_o(wait_cnt)
    );

    function automatic logic [7:0] init_val(input int i);
        return (i == 16) ? 8'h5A : 8'((i * 37 + 11) & 255);
    endfunction

    // Memory macro: synchronous, one-cycle read latency.
    logic [7:0] mem [256];
    bit mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         t_req;
        int         exp_lat;
    } txn_t;

    txn_t cpu_q[$];
    txn_t dma_q[$];
    logic [7:0] shadow [256];
    bit   sb_ready = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_wait = 0;
    logic bus_seen = 1'b0;
    logic bus_we;
    logic [7:0] bus_addr, bus_wdata;

`ifdef MEM_ARB_WAIT_CNT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score_ack();
        txn_t  t;
        logic  side;
        int    lat;
        string nm;
        check("single_ack", {31'd0, cpu_ack & dma_ack}, 32'd0);
        side = dma_ack;
        if (!side) begin
            check("cpu_sb_nonempty", {31'd0, cpu_q.size() != 0}, 32'd1);
            if (cpu_q.size() == 0) return;
            t = cpu_q.pop_front();
        end else begin
            check("dma_sb_nonempty", {31'd0, dma_q.size() != 0}, 32'd1);
            if (dma_q.size() == 0) return;
            t = dma_q.pop_front();
        end
        check("bus_seen", {31'd0, bus_seen}, 32'd1);
        check("bus_cmd", {15'd0, bus_we, bus_addr, bus_wdata}, {15'd0, t.we, t.addr, t.wdata});
        bus_seen = 1'b0;
        lat = cyc - t.t_req;
        if (t.exp_lat > 0) check("latency", lat, t.exp_lat);
        else               check("latency_bound", {31'd0, (lat >= 2 && lat <= 5)}, 32'd1);
        if (!t.we) begin
            nm = side ? "dma_rdata" : "cpu_rdata";
            check(nm, {24'd0, side ? dma_rdata : cpu_rdata}, {24'd0, shadow[t.addr]});
        end else begin
            shadow[t.addr] = t.wdata;
        end
        check("other_rdata_zero", {24'd0, side ? cpu_rdata : dma_rdata}, 32'd0);
        if (!side) exp_wait = (exp_wait + lat - 1 > 255) ? 255 : exp_wait + lat - 1;
    endtask

    always @(negedge clk) begin
        if (!sb_ready) begin
            for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
            sb_ready = 1'b1;
        end
        if (mem_en) begin
            bus_seen  = 1'b1;
            bus_we    = mem_we;
            bus_addr  = mem_addr;
            bus_wdata = mem_wdata;
        end
        if (cpu_ack || dma_ack) score_ack();
        if (reset) begin
            exp_wait = 0;
            bus_seen = 1'b0;
        end
    end

    task automatic set_req(input logic side, input logic v);
        if (side) dma_req = v;
        else      cpu_req = v;
    endtask

    task automatic drive(input logic side, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input int exp_lat);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.t_req = cyc; t.exp_lat = exp_lat;
        if (side) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
            dma_q.push_back(t);
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
            cpu_q.push_back(t);
        end
    endtask

    task automatic wait_ack(input logic side);
        int   k   = 0;
        logic got = 1'b0;
        while (!got && k < 12) begin
            @(negedge clk);
            got = side ? dma_ack : cpu_ack;
            k++;
        end
        check(side ? "dma_ack_timeout" : "cpu_ack_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic access(input logic side, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input int exp_lat, input bit keep);
        drive(side, we, addr, wdata, exp_lat);
        wait_ack(side);
        @(posedge clk); #1;
        if (!keep) set_req(side, 1'b0);
    endtask

    task automatic burst(input logic side, input int n, input int lat0, input int latn);
        for (int i = 0; i < n; i++) begin
            access(side, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom),
                   (i == 0) ? lat0 : latn, i < n - 1);
        end
    endtask

    task automatic rand_run(input logic side, input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                set_req(side, 1'b0);
                repeat (gap) begin @(posedge clk); #1; end
            end
            access(side, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), 0, 1'b1);
        end
        set_req(side, 1'b0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, {27'd0, cpu_ack, dma_ack, mem_en, mem_we, busy}, 32'd0);
        check({name, "_data"}, {cpu_rdata, dma_rdata, mem_addr, mem_wdata}, 32'd0);
        check({name, "_wait"}, {24'd0, wait_cnt}, 32'd0);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); check_zero(name);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        do_reset("reset");

        // CPU read alone
        drive(1'b0, 1'b0, 8'h10, 8'h00, 2);
        @(negedge clk); check("t1_c0_mem_en", {31'd0, mem_en}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_c1_mem_en", {31'd0, mem_en}, 32'd1);
        check("t1_c1_addr", {24'd0, mem_addr}, 32'h10);
        wait_ack(1'b0);
        check("t1_rdata", {24'd0, cpu_rdata}, 32'h5A);
        check("t1_dma_ack", {31'd0, dma_ack}, 32'd0);
        @(posedge clk); #1; cpu_req = 1'b0;

        // DMA write, then CPU read-back
        drive(1'b1, 1'b1, 8'h03, 8'hC3, 2);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_grant_bus", {15'd0, mem_we, mem_addr, mem_wdata}, {15'd0, 1'b1, 8'h03, 8'hC3});
        wait_ack(1'b1);
        @(posedge clk); #1; dma_req = 1'b0;
        drive(1'b0, 1'b0, 8'h03, 8'h00, 2);
        wait_ack(1'b0);
        check("t2_readback", {24'd0, cpu_rdata}, 32'hC3);
        @(posedge clk); #1; cpu_req = 1'b0;

        // Input change while in GRANT is ignored
        drive(1'b0, 1'b0, 8'h20, 8'h00, 2);
        @(posedge clk); #1;
        cpu_addr = 8'h21; cpu_we = 1'b1; cpu_wdata = 8'hFF;
        @(negedge clk);
        check("t4_latched", {15'd0, mem_we, mem_addr, mem_wdata}, {15'd0, 1'b0, 8'h20, 8'h00});
        wait_ack(1'b0);
        @(posedge clk); #1; cpu_req = 1'b0; cpu_we = 1'b0;

        // Tie after reset, then strict alternation with both requests held
        do_reset("reset2");
        fork
            burst(1'b0, 3, 2, 5);
            burst(1'b1, 3, 5, 5);
        join

        // CPU stalls behind one DMA access
        do_reset("reset3");
        fork
            access(1'b1, 1'b0, 8'h05, 8'h00, 2, 1'b0);
            begin
                @(posedge clk); #1;
                access(1'b0, 1'b0, 8'h06, 8'h00, 4, 1'b0);
            end
        join
        @(negedge clk);
        check("t6_wait_cnt", {24'd0, wait_cnt}, WAIT_EN ? 32'd3 : 32'd0);
        check("t6_wait_model", {24'd0, wait_cnt}, WAIT_EN ? exp_wait : 32'd0);

        // Reset asserted in DONE
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h07, 8'h00, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; cpu_req = 1'b0;
        @(negedge clk); check("t5_ack_in_done", {31'd0, cpu_ack}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk); check_zero("t5_after_reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Random traffic, then heavy contention to saturate the stall counter
        fork
            rand_run(1'b0, 150);
            rand_run(1'b1, 150);
        join
        fork
            burst(1'b0, 40, 0, 0);
            burst(1'b1, 40, 0, 0);
        join
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("wait_cnt_model", {24'd0, wait_cnt}, WAIT_EN ? exp_wait : 32'd0);
        check("wait_cnt_sat", {24'd0, wait_cnt}, WAIT_EN ? 32'd255 : 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("sb_drained", cpu_q.size() + dma_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
